// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_ctrl
//  Description : Armed, triggered and decimated ADC capture into the sample FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl #(
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 24,
    parameter int DECIM_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   adc_data_1,
    input  logic [DATA_W-1:0]   adc_data_2,
    input  logic                data_valid,
    input  logic                link_ready,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          trig_mode,
    input  logic [DATA_W-1:0]   trig_level,
    input  logic [LEN_W-1:0]    capture_len,
    input  logic [DECIM_W-1:0]  decim,
    input  logic                fifo_prog_full,
    output logic [2*DATA_W-1:0] fifo_din,
    output logic                fifo_wr_en,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [LEN_W-1:0]    words_written
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   level_q, level_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DECIM_W-1:0]  decim_q, decim_d;
    logic [2*DATA_W-1:0] din_q, din_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [LEN_W-1:0]    words_q, words_d;

    logic                strobe;
    logic                fire;
    logic                last_phase;
    logic                keep;
    logic [LEN_W-1:0]    words_inc;

    assign strobe    = data_valid && link_ready;
    assign words_inc = words_q + LEN_W'(1);
    // Ratios 0 and 1 both keep every accepted sample.
    assign last_phase = (decim_q <= DECIM_W'(1)) || (dcnt_q == decim_q - DECIM_W'(1));

    always_comb begin
        fire = 1'b0;
        case (mode_q)
            2'd1:    fire = prev_vld_q && (prev_q <  level_q) && (adc_data_1 >= level_q);
            2'd2:    fire = prev_vld_q && (prev_q >= level_q) && (adc_data_1 <  level_q);
            default: fire = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        dcnt_d     = dcnt_q;
        mode_d     = mode_q;
        level_d    = level_q;
        len_d      = len_q;
        decim_d    = decim_q;
        din_d      = din_q;
        wr_en_d    = 1'b0;
        ovf_d      = ovf_q;
        words_d    = words_q;
        keep       = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            prev_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_d     = trig_mode;
                        level_d    = trig_level;
                        len_d      = capture_len;
                        decim_d    = decim;
                        words_d    = '0;
                        ovf_d      = 1'b0;
                        prev_vld_d = 1'b0;
                        dcnt_d     = '0;
                        state_d    = (capture_len == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (strobe) begin
                        prev_d     = adc_data_1;
                        prev_vld_d = 1'b1;
                        if (fire) begin
                            dcnt_d = '0;
                            keep   = 1'b1;
                        end
                    end
                end
                default: begin
                    if (strobe) begin
                        if (last_phase) begin
                            dcnt_d = '0;
                            keep   = 1'b1;
                        end else begin
                            dcnt_d = dcnt_q + DECIM_W'(1);
                        end
                    end
                end
            endcase

            // A full FIFO drops the kept sample and terminates the capture.
            if (keep) begin
                if (fifo_prog_full) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    din_d   = {adc_data_1, adc_data_2};
                    wr_en_d = 1'b1;
                    words_d = words_inc;
                    state_d = (words_inc == len_q) ? S_DONE : S_CAPT;
                end
            end
        end

        busy_d = (state_d == S_WAIT) || (state_d == S_CAPT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            dcnt_q     <= '0;
            mode_q     <= '0;
            level_q    <= '0;
            len_q      <= '0;
            decim_q    <= '0;
            din_q      <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            dcnt_q     <= dcnt_d;
            mode_q     <= mode_d;
            level_q    <= level_d;
            len_q      <= len_d;
            decim_q    <= decim_d;
            din_q      <= din_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            words_q    <= words_d;
        end
    end

    assign fifo_din      = din_q;
    assign fifo_wr_en    = wr_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign words_written = words_q;

endmodule
`default_nettype wire

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Triggered capture sequencer between the SYZYGY ADC deserializer output and the dual-clock sample FIFO.
- Replaces the free-running "write whenever fill is asserted" gating.
- Waits for an arm pulse, then an immediate or threshold trigger on channel 1.
- Writes a programmed number of optionally decimated {ch1, ch2} words into the FIFO, then reports done/overflow status back to host endpoints.
- Runs entirely in the ADC data clock domain.

Parameters:
DATA_W, 16, width of each ADC channel word
LEN_W, 24, width of capture length and word counter
DECIM_W, 8, width of decimation ratio

Ports:
clk  in  1  ADC data clock (adc_data_clk)
reset_n  in  1  synchronous, active-low reset
adc_data_1  in  DATA_W  channel 1 sample
adc_data_2  in  DATA_W  channel 2 sample
data_valid  in  1  deserializer framing/bitslip valid
link_ready  in  1  MMCM locked AND IDELAY ready
start  in  1  single-cycle arm pulse (host trigger)
abort  in  1  single-cycle abort pulse
trig_mode  in  2  0 immediate, 1 rising ch1 crossing, 2 falling ch1 crossing, 3 treated as 0
trig_level  in  DATA_W  ch1 threshold, unsigned compare
capture_len  in  LEN_W  words to write
decim  in  DECIM_W  keep 1 of every decim accepted samples; 0 and 1 both mean keep all
fifo_prog_full  in  1  FIFO programmable-full flag
fifo_din  out  2*DATA_W  {adc_data_1, adc_data_2}
fifo_wr_en  out  1  FIFO write strobe
busy  out  1  high in WAIT_TRIG or CAPTURE
done  out  1  high in DONE
overflow  out  1  sticky: capture terminated by prog_full
words_written  out  LEN_W  count of fifo_wr_en pulses in current capture

Behaviour:
- reset_n low at a clk edge: state IDLE. All outputs 0; internal prev-sample, decimation counter and latched config are 0. Reset overrides all other inputs, including mid-capture.
- Accepted sample (strobe): data_valid && link_ready in the same cycle. No strobe means nothing advances. Dropping link_ready mid-capture stalls the capture; it does not abort.
- Config latch: trig_mode, trig_level, capture_len and decim are latched when start is accepted. Later changes to these inputs are ignored until the next start.
- States:
  - IDLE: on start go to WAIT_TRIG. On that start edge clear done, overflow and words_written.
  - WAIT_TRIG: on a strobe, evaluate the trigger against the registered previous ch1 sample (prev):
    - mode 1 fires when prev < trig_level and cur >= trig_level.
    - mode 2 fires when prev >= trig_level and cur < trig_level.
    - modes 0/3 fire on the first strobe.
    - prev is not valid until one strobe has occurred in WAIT_TRIG, so modes 1/2 cannot fire on the first strobe after arming.
    - The triggering sample is the first kept sample. Decimation counter resets to 0 at trigger.
  - CAPTURE: on each strobe increment the decimation counter modulo max(decim,1); keep the sample when the counter is 0.
  - DONE: holds done=1. start returns to WAIT_TRIG (clears status). Otherwise stays.
- Kept sample at edge t: fifo_din is registered at edge t, and fifo_wr_en is high for exactly the cycle after edge t. fifo_din holds its value otherwise. words_written increments at edge t, so it equals the number of wr_en pulses issued including the current one.
- Completion: when the kept sample makes words_written equal capture_len, go to DONE at that same edge. The last fifo_wr_en and done=1 appear in the same cycle.
- capture_len = 0: start goes directly to DONE. words_written = 0, no writes.
- Overflow: if fifo_prog_full=1 at an edge where a sample would be kept (WAIT_TRIG trigger or CAPTURE keep), that sample is dropped (no wr_en). overflow is set, and the state goes to DONE.
- abort: in any state, next state is IDLE. done is cleared. overflow and words_written hold their values for readback. abort wins over start in the same cycle.
- start while busy: ignored.
- Counter: words_written never exceeds capture_len, so it cannot wrap.

Test Plan:
1. trig_mode=0, capture_len=4, decim=1, ch1=0x0100+n, ch2=0x0200+n, strobe every cycle, start at cycle 10 -> exactly 4 wr_en pulses. fifo_din = 0x01000200..0x01030203. done rises together with the 4th pulse; words_written=4; busy falls.
2. trig_mode=0, decim=3, capture_len=3, ch1 counting from 0, data_valid toggling 1/0 -> writes ch1 = 0, 3, 6. Idle valid cycles do not advance the decimation counter.
3. trig_mode=1, trig_level=0x0800, ch1 ramps 0x07E0 step 8 -> first written ch1=0x0800. trig_mode=2 on a falling ramp from 0x0810 -> first written 0x07F8.
4. capture_len=100, fifo_prog_full raised after 37 writes -> words_written=37, overflow=1, done=1, no further wr_en. Next start clears overflow.
5. abort at word 10 of 50 -> IDLE, done=0, words_written=10, no further writes. Repeat with reset_n low mid-capture -> all outputs 0 at the next edge.
6. capture_len=0 -> done the cycle after start, zero writes. start while busy -> no effect. link_ready low for 20 cycles mid-capture -> capture stalls, then resumes with the correct total count.
